regfile_wb_arbiter: RTL and testbench

- Sequences the single write port of the 32x32 register file (x0 hardwired to zero).
- Shares that port between two writeback requesters: ALU (port A) and load/store unit (port M), with round-robin arbitration.
- Keeps a pending-write scoreboard so issue logic can reserve destinations and detect RAW hazards on two read addresses.
- Sits between execute/memory stages and register_file; drives its we/w_addr/w_data.

---
 rtl/regfile_wb_arbiter.sv | 122 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Writeback port sequencer for the 32x32 register file: round-robin ALU/LSU arbitration,
// registered write port, and a pending-write scoreboard for RAW hazard checks.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NREG   = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rsv_valid,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ready,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              m_valid,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_data,
    output logic              m_ready,
    output logic              we,
    output logic [ADDR_W-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    input  logic [ADDR_W-1:0] chk_addr1,
    input  logic [ADDR_W-1:0] chk_addr2,
    output logic              busy1,
    output logic              busy2,
    output logic [CNT_W-1:0]  conflict_cnt,
    output logic              err_unrsv
);

    localparam logic PRIO_A = 1'b0;
    localparam logic PRIO_M = 1'b1;

    logic              prio_q, prio_d;
    logic [NREG-1:0]   busy_q, busy_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              a_hs, m_hs;

    always_comb begin
        a_ready = !m_valid || (prio_q == PRIO_A);
        m_ready = !a_valid || (prio_q == PRIO_M);
        a_hs    = a_valid && a_ready;
        m_hs    = m_valid && m_ready;
    end

    // Handshakes are mutually exclusive: with both valid, exactly one ready is high.
    always_comb begin
        prio_d   = prio_q;
        we_d     = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        if (a_valid && m_valid) begin
            prio_d = a_hs ? PRIO_M : PRIO_A;
        end
        if (a_hs) begin
            w_addr_d = a_addr;
            w_data_d = a_data;
            we_d     = (a_addr != '0);
        end else if (m_hs) begin
            w_addr_d = m_addr;
            w_data_d = m_data;
            we_d     = (m_addr != '0);
        end
    end

    assign rsv_ready = (rsv_addr == '0) || !busy_q[rsv_addr];

    // Commit clears first so a same-edge reservation of that address wins.
    always_comb begin
        busy_d = busy_q;
        if (we_q) begin
            busy_d[w_addr_q] = 1'b0;
        end
        if (rsv_valid && rsv_ready && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        if (a_valid && m_valid && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        err_d = err_q || (we_q && (w_addr_q != '0) && !busy_q[w_addr_q]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q   <= PRIO_A;
            busy_q   <= '0;
            we_q     <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            prio_q   <= prio_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign we           = we_q;
    assign w_addr       = w_addr_q;
    assign w_data       = w_data_q;
    assign busy1        = busy_q[chk_addr1];
    assign busy2        = busy_q[chk_addr2];
    assign conflict_cnt = cnt_q;
    assign err_unrsv    = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter; each vector is driven just after a
// rising edge and all outputs are compared before the following edge.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rsv_valid, a_valid, m_valid;
    logic [4:0]  rsv_addr, a_addr, m_addr, chk_addr1, chk_addr2, w_addr;
    logic [31:0] a_data, m_data, w_data;
    logic        rsv_ready, a_ready, m_ready, we, busy1, busy2, err_unrsv;
    logic [15:0] conflict_cnt;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .rsv_valid    (rsv_valid),
        .rsv_addr     (rsv_addr),
        .rsv_ready    (rsv_ready),
        .a_valid      (a_valid),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .m_valid      (m_valid),
        .m_addr       (m_addr),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .we           (we),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .chk_addr1    (chk_addr1),
        .chk_addr2    (chk_addr2),
        .busy1        (busy1),
        .busy2        (busy2),
        .conflict_cnt (conflict_cnt),
        .err_unrsv    (err_unrsv)
    );

    typedef struct packed {
        logic        rv;
        logic [4:0]  ra;
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic [4:0]  c1;
        logic [4:0]  c2;
        // expected outputs
        logic        e_rr;
        logic        e_ar;
        logic        e_mr;
        logic        e_we;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_b1;
        logic        e_b2;
        logic        e_err;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 25;
    localparam logic [31:0] DB  = 32'hDEAD_BEEF;
    localparam logic [31:0] A3  = 32'hA000_0003;
    localparam logic [31:0] M4  = 32'h4000_0004;
    localparam logic [31:0] A10 = 32'hA000_000A;
    localparam logic [31:0] M11 = 32'h4000_000B;

    vec_t tbl [NV];
    vec_t v;
    int   n_vec = 0;
    int   n_mis = 0;

    task automatic apply(input vec_t t, input string name);
        logic [59:0] act, exp;
        rsv_valid = t.rv; rsv_addr = t.ra;
        a_valid = t.av; a_addr = t.aa; a_data = t.ad;
        m_valid = t.mv; m_addr = t.ma; m_data = t.md;
        chk_addr1 = t.c1; chk_addr2 = t.c2;
        #1;
        act = {rsv_ready, a_ready, m_ready, we, w_addr, w_data, busy1, busy2, err_unrsv,
               conflict_cnt};
        exp = {t.e_rr, t.e_ar, t.e_mr, t.e_we, t.e_wa, t.e_wd, t.e_b1, t.e_b2, t.e_err,
               t.e_cnt};
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got rr/ar/mr/we=%b%b%b%b wa=%0d wd=%h b=%b%b err=%b cnt=%0d ; want rr/ar/mr/we=%b%b%b%b wa=%0d wd=%h b=%b%b err=%b cnt=%0d",
                     name, rsv_ready, a_ready, m_ready, we, w_addr, w_data, busy1, busy2,
                     err_unrsv, conflict_cnt, t.e_rr, t.e_ar, t.e_mr, t.e_we, t.e_wa, t.e_wd,
                     t.e_b1, t.e_b2, t.e_err, t.e_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rsv, A req, M req, chk | rr ar mr we wa wd b1 b2 err cnt
        tbl[0]  = '{1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0,
                    1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b0, 5'd0, 1'b1, 5'd5, DB, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0,
                    1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[2]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0,
                    1'b1, 1'b1, 1'b1, 1'b1, 5'd5, DB, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0,
                    1'b1, 1'b1, 1'b1, 1'b0, 5'd5, DB, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4,
                    1'b1, 1'b1, 1'b1, 1'b0, 5'd5, DB, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[5]  = '{1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4,
                    1'b1, 1'b1, 1'b1, 1'b0, 5'd5, DB, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[6]  = '{1'b1, 5'd10, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4,
                    1'b1, 1'b1, 1'b1, 1'b0, 5'd5, DB, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[7]  = '{1'b1, 5'd11, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd11,
                    1'b1, 1'b1, 1'b1, 1'b0, 5'd5, DB, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[8]  = '{1'b0, 5'd0, 1'b1, 5'd3, A3, 1'b1, 5'd4, M4, 5'd3, 5'd4,
                    1'b1, 1'b1, 1'b0, 1'b0, 5'd5, DB, 1'b1, 1'b1, 1'b0, 16'd0};
        tbl[9]  = '{1'b0, 5'd0, 1'b1, 5'd10, A10, 1'b1, 5'd4, M4, 5'd3, 5'd4,
                    1'b1, 1'b0, 1'b1, 1'b1, 5'd3, A3, 1'b1, 1'b1, 1'b0, 16'd1};
        tbl[10] = '{1'b0, 5'd0, 1'b1, 5'd10, A10, 1'b1, 5'd11, M11, 5'd10, 5'd11,
                    1'b1, 1'b1, 1'b0, 1'b1, 5'd4, M4, 1'b1, 1'b1, 1'b0, 16'd2};
        tbl[11] = '{1'b0, 5'd0, 1'b1, 5'd10, A10, 1'b1, 5'd11, M11, 5'd10, 5'd11,
                    1'b1, 1'b0, 1'b1, 1'b1, 5'd10, A10, 1'b1, 1'b1, 1'b0, 16'd3};
        tbl[12] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd11,
                    1'b1, 1'b1, 1'b1, 1'b1, 5'd11, M11, 1'b0, 1'b1, 1'b0, 16'd4};
        tbl[13] = '{1'b0, 5'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 5'd0, 5'd11,
                    1'b1, 1'b1, 1'b0, 1'b0, 5'd11, M11, 1'b0, 1'b0, 1'b0, 16'd4};
        tbl[14] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
                    1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h1234, 1'b0, 1'b0, 1'b0, 16'd4};
        tbl[15] = '{1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0,
                    1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h1234, 1'b0, 1'b0, 1'b0, 16'd4};
        tbl[16] = '{1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0,
                    1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h1234, 1'b1, 1'b0, 1'b0, 16'd4};
        tbl[17] = '{1'b1, 5'd7, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0,
                    1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h1234, 1'b1, 1'b0, 1'b0, 16'd4};
        tbl[18] = '{1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0,
                    1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 1'b0, 1'b0, 16'd4};
        tbl[19] = '{1'b1, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0,
                    1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h77, 1'b0, 1'b0, 1'b0, 16'd4};
        tbl[20] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0,
                    1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h77, 1'b1, 1'b0, 1'b0, 16'd4};
        tbl[21] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99, 5'd9, 5'd7,
                    1'b1, 1'b1, 1'b1, 1'b0, 5'd7, 32'h77, 1'b0, 1'b1, 1'b0, 16'd4};
        tbl[22] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd7,
                    1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 1'b1, 1'b0, 16'd4};
        tbl[23] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd7,
                    1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h99, 1'b0, 1'b1, 1'b1, 16'd4};
        tbl[24] = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd7,
                    1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h99, 1'b0, 1'b1, 1'b1, 16'd4};

        rst = 1'b1;
        rsv_valid = 1'b0; rsv_addr = '0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        m_valid = 1'b0; m_addr = '0; m_data = '0;
        chk_addr1 = '0; chk_addr2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        v = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0,
              1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0};
        apply(v, "reset_state");

        for (int i = 0; i < NV; i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Mid-operation reset with x2/x3 reserved and a grant pending at the reset edge.
        v = '{1'b1, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3,
              1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h99, 1'b0, 1'b0, 1'b1, 16'd4};
        apply(v, "rsv_x2");
        v = '{1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3,
              1'b1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h99, 1'b1, 1'b0, 1'b1, 16'd4};
        apply(v, "rsv_x3");
        rst = 1'b1;
        v = '{1'b0, 5'd0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33, 5'd2, 5'd3,
              1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 32'h99, 1'b1, 1'b1, 1'b1, 16'd4};
        apply(v, "rst_edge");
        rst = 1'b0;
        v = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3,
              1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0};
        apply(v, "after_rst");
        v = '{1'b0, 5'd0, 1'b1, 5'd2, 32'h22, 1'b1, 5'd3, 32'h33, 5'd2, 5'd3,
              1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 16'd0};
        apply(v, "prio_a_after_rst");
        v = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3,
              1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 1'b0, 16'd1};
        apply(v, "post_rst_write");
        v = '{1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd3,
              1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 32'h22, 1'b0, 1'b0, 1'b1, 16'd1};
        apply(v, "post_rst_err");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
